// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared mode constants and Gray/binary conversion functions
package gray_pkg;

  localparam logic MODE_B2G = 1'b0;
  localparam logic MODE_G2B = 1'b1;

  localparam int MAX_W = 32;
  typedef logic [MAX_W-1:0] word_t;

  // Callers zero-extend narrower words; zero upper bits leave the low bits unaffected.
  function automatic word_t bin2gray(input word_t b);
    return b ^ (b >> 1);
  endfunction

  // Prefix-XOR running down from the MSB.
  function automatic word_t gray2bin(input word_t g);
    word_t b;
    b = '0;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_pipe_stage.sv
// rtl/gray_pipe_stage.sv - one pipeline slot: valid flag plus payload register with load enable
module gray_pipe_stage #(
  parameter int DW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic          drain,
  input  logic [DW-1:0] d,
  output logic          valid,
  output logic [DW-1:0] q
);

  // Load wins over drain so a slot can be emptied and refilled on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (ld) begin
      valid <= 1'b1;
      q     <= d;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/gray_code_conv_pipe.sv
// rtl/gray_code_conv_pipe.sv - two-stage valid/ready Gray<->binary converter with transfer counter
module gray_code_conv_pipe
  import gray_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode,
  output logic [CNT_W-1:0] done_cnt
);

  // G2B is split: S1 resolves the upper H bits, S2 the lower L bits.
  localparam int L = WIDTH / 2;

  logic             s1_ld;
  logic             s2_ld;
  logic             s1_valid;
  logic             s2_valid;
  logic [WIDTH:0]   s1_q;
  logic [WIDTH:0]   s2_q;
  logic [WIDTH-1:0] s1_conv;
  logic [WIDTH-1:0] s2_conv;
  logic             s1_mode;
  logic [WIDTH-1:0] s1_word;

  assign s1_mode = s1_q[WIDTH];
  assign s1_word = s1_q[WIDTH-1:0];

  assign s1_ld    = in_valid && in_ready;
  assign s2_ld    = s1_valid && (!s2_valid || out_ready);
  assign in_ready = !s1_valid || s2_ld;

  // S1 conversion: full B2G, or upper-half prefix-XOR for G2B (lower half left as Gray).
  always_comb begin
    s1_conv = '0;
    if (in_mode == MODE_B2G) begin
      s1_conv = in_data ^ (in_data >> 1);
    end else begin
      s1_conv = in_data;
      for (int i = WIDTH - 2; i >= L; i--) begin
        s1_conv[i] = s1_conv[i+1] ^ in_data[i];
      end
    end
  end

  // S2 conversion: finish the prefix-XOR into the lower half for G2B; B2G passes through.
  always_comb begin
    s2_conv = s1_word;
    if (s1_mode == MODE_G2B) begin
      for (int i = L - 1; i >= 0; i--) begin
        s2_conv[i] = s2_conv[i+1] ^ s1_word[i];
      end
    end
  end

  gray_pipe_stage #(.DW(WIDTH + 1)) u_s1 (
    .clk   (clk),
    .rst   (rst),
    .ld    (s1_ld),
    .drain (s2_ld),
    .d     ({in_mode, s1_conv}),
    .valid (s1_valid),
    .q     (s1_q)
  );

  gray_pipe_stage #(.DW(WIDTH + 1)) u_s2 (
    .clk   (clk),
    .rst   (rst),
    .ld    (s2_ld),
    .drain (out_ready),
    .d     ({s1_mode, s2_conv}),
    .valid (s2_valid),
    .q     (s2_q)
  );

  assign out_valid = s2_valid;
  assign out_mode  = s2_q[WIDTH];
  assign out_data  = s2_q[WIDTH-1:0];

  // Count completed output transfers, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_cnt <= '0;
    end else if (out_valid && out_ready && (done_cnt != '1)) begin
      done_cnt <= done_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_gray_code_conv_pipe.sv
// tb/tb_gray_code_conv_pipe.sv - scoreboard bench for gray_code_conv_pipe
module tb_gray_code_conv_pipe;
  import gray_pkg::*;

  localparam int W  = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_mode = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic          out_mode;
  logic [CW-1:0] done_cnt;

  logic          in_valid8 = 1'b0;
  logic          in_ready8;
  logic          in_mode8 = 1'b0;
  logic [7:0]    in_data8 = '0;
  logic          out_valid8;
  logic          out_ready8 = 1'b1;
  logic [7:0]    out_data8;
  logic          out_mode8;
  logic [15:0]   done_cnt8;

  always #5 clk = ~clk;

  gray_code_conv_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_mode(out_mode), .done_cnt(done_cnt)
  );

  gray_code_conv_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .in_mode(in_mode8),
    .in_data(in_data8), .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
    .out_mode(out_mode8), .done_cnt(done_cnt8)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ready_mode = 1;  // 0 low, 1 high, 2 random

  typedef struct {
    logic         mode;
    logic [W-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   model_cnt  = 0;
  int   xfer_total = 0;
  logic held       = 1'b0;
  logic [W-1:0] held_data;
  logic held_mode;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  word_t pw, pr;
  // Input monitor: every accepted word pushes its reference result.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else if (in_valid && in_ready) begin
      exp_t e;
      pw = '0;
      pw[W-1:0] = in_data;
      pr = (in_mode == MODE_G2B) ? gray2bin(pw) : bin2gray(pw);
      e.mode = in_mode;
      e.data = pr[W-1:0];
      sb.push_back(e);
    end
  end

  // Output monitor: pops and compares on each transfer, checks hold and the counter.
  always @(negedge clk) begin
    if (rst) begin
      model_cnt = 0;
      held = 1'b0;
    end else begin
      chk("done_cnt", 32'(done_cnt), (model_cnt > 15) ? 32'd15 : 32'(model_cnt));
      if (held) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(held_data));
        chk("hold_mode", 32'(out_mode), 32'(held_mode));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("stale_output", 32'(out_data), 32'hDEAD);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_data", 32'(out_data), 32'(e.data));
          chk("out_mode", 32'(out_mode), 32'(e.mode));
        end
        model_cnt++;
        xfer_total++;
      end
      held      = out_valid && !out_ready;
      held_data = out_data;
      held_mode = out_mode;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the acceptance edge.
  task automatic send(input logic m, input logic [W-1:0] d, output int waits);
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    waits    = 0;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_mode  = 1'($urandom_range(0, 1));
    in_data  = W'($urandom);
  endtask

  task automatic directed(input string name, input logic m, input logic [W-1:0] d,
                          input logic [W-1:0] exp_d);
    int acc;
    int n;
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    @(negedge clk);
    chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
    acc = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 10) begin
      n++;
      @(negedge clk);
    end
    chk({name, "_latency"}, 32'(cyc - acc), 32'd2);
    chk({name, "_data"}, 32'(out_data), 32'(exp_d));
    chk({name, "_mode"}, 32'(out_mode), 32'(m));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    int stalls;
    int x0;
    int n;
    word_t g;
    word_t r;
    logic [W-1:0] bw [3];
    logic         bm [3];

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_mode", 32'(out_mode), 32'd0);
    chk("rst_done_cnt", 32'(done_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid8", 32'(out_valid8), 32'd0);
    @(posedge clk);
    #1;

    directed("b2g_1011", MODE_B2G, 4'b1011, 4'b1110);
    directed("g2b_1110", MODE_G2B, 4'b1110, 4'b1011);

    // 8-bit instance: G2B 0xFF -> 0xAA
    in_valid8 = 1'b1;
    in_mode8  = MODE_G2B;
    in_data8  = 8'hFF;
    @(negedge clk);
    chk("w8_in_ready", 32'(in_ready8), 32'd1);
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid8 && n < 10) begin
      n++;
      @(negedge clk);
    end
    chk("w8_out_valid", 32'(out_valid8), 32'd1);
    chk("w8_data", 32'(out_data8), 32'hAA);
    r = gray2bin(32'hFF);
    chk("w8_model", 32'(out_data8), 32'(r[7:0]));
    chk("w8_mode", 32'(out_mode8), 32'd1);
    @(posedge clk);
    #1;
    chk("w8_done_cnt", 32'(done_cnt8), 32'd1);

    // Back-to-back sweep, alternating mode per word.
    stalls = 0;
    x0 = xfer_total;
    for (int i = 0; i < 16; i++) begin
      send(MODE_B2G, W'(i), w);
      stalls += w;
      g = bin2gray(word_t'(i));
      send(MODE_G2B, g[W-1:0], w);
      stalls += w;
    end
    chk("sweep_stalls", 32'(stalls), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("sweep_outputs", 32'(xfer_total - x0), 32'd32);
    chk("sweep_drained", 32'(sb.size()), 32'd0);

    // Backpressure: out_ready low, three words offered.
    ready_mode = 0;
    for (int i = 0; i < 3; i++) begin
      bw[i] = W'($urandom);
      bm[i] = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #1;
    send(bm[0], bw[0], w);
    send(bm[1], bw[1], w);
    in_valid = 1'b1;
    in_mode  = bm[2];
    in_data  = bw[2];
    g = '0;
    g[W-1:0] = bw[0];
    r = (bm[0] == MODE_G2B) ? gray2bin(g) : bin2gray(g);
    repeat (4) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_data", 32'(out_data), 32'(r[W-1:0]));
    end
    @(posedge clk);
    #1;
    ready_mode = 1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 10) begin
      n++;
      @(negedge clk);
    end
    chk("bp_resume", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("bp_drained", 32'(sb.size()), 32'd0);

    // Reset with two words in flight.
    ready_mode = 0;
    @(posedge clk);
    #1;
    send(1'($urandom_range(0, 1)), W'($urandom), w);
    send(1'($urandom_range(0, 1)), W'($urandom), w);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ready_mode = 1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_done_cnt", 32'(done_cnt), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    repeat (5) begin
      @(negedge clk);
      chk("midrst_no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Saturation: 20 transfers into a 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      send(1'($urandom_range(0, 1)), W'($urandom), w);
    end
    repeat (4) @(posedge clk);
    #1;
    chk("sat_done_cnt", 32'(done_cnt), 32'hF);

    // Random traffic with random backpressure and input gaps.
    ready_mode = 2;
    for (int i = 0; i < 150; i++) begin
      send(1'($urandom_range(0, 1)), W'($urandom), w);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    ready_mode = 1;
    repeat (6) @(posedge clk);
    #1;
    chk("rand_drained", 32'(sb.size()), 32'd0);
    chk("rand_no_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
